dual_port_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's two memory ports (A: fetch, B: data).

---
 rtl/dual_port_mem_responder_if.sv | 33 +++
 rtl/dual_port_mem_responder.sv | 127 ++++++++++++
 tb/tb_dual_port_mem_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_mem_responder_if.sv
// Request/response bundle for the two CPU memory ports (A: fetch, B: data).
// master = CPU side, slave = memory responder side.
interface dual_port_mem_responder_if;
    logic        read_a;
    logic        write_a;
    logic [1:0]  wmask_a;
    logic [15:0] address_a;
    logic [15:0] wdata_a;
    logic        resp_a;
    logic [15:0] rdata_a;

    logic        read_b;
    logic        write_b;
    logic [1:0]  wmask_b;
    logic [15:0] address_b;
    logic [15:0] wdata_b;
    logic        resp_b;
    logic [15:0] rdata_b;

    modport master (
        output read_a, write_a, wmask_a, address_a, wdata_a,
        input  resp_a, rdata_a,
        output read_b, write_b, wmask_b, address_b, wdata_b,
        input  resp_b, rdata_b
    );

    modport slave (
        input  read_a, write_a, wmask_a, address_a, wdata_a,
        output resp_a, rdata_a,
        input  read_b, write_b, wmask_b, address_b, wdata_b,
        output resp_b, rdata_b
    );
endinterface

// File: rtl/dual_port_mem_responder.sv
// Single-ported word memory serving two request ports with alternating
// arbitration, a programmable BUSY latency and a one-cycle resp pulse.
module dual_port_mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    dual_port_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int unsigned DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t                 state_q;
    logic                   port_q;      // 0 = A, 1 = B
    logic                   last_q;      // port granted most recently
    logic                   wr_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [1:0]             wmask_q;
    logic [15:0]            wdata_q;
    logic [3:0]             cnt_q;
    logic                   resp_a_q;
    logic                   resp_b_q;
    logic [15:0]            rdata_a_q;
    logic [15:0]            rdata_b_q;
    logic [15:0]            mem [DEPTH];

    logic                   pend_a;
    logic                   pend_b;
    logic                   grant_b;
    logic                   access_now;
    logic [ADDR_BITS-1:0]   addr_d;
    logic [1:0]             wmask_d;
    logic [15:0]            wdata_d;
    logic                   wr_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address_a[15:ADDR_BITS+1], bus.address_a[0],
                                bus.address_b[15:ADDR_BITS+1], bus.address_b[0]};

    always_comb begin
        pend_a     = bus.read_a | bus.write_a;
        pend_b     = bus.read_b | bus.write_b;
        // B wins when alone, or when both pend and A was served last
        grant_b    = pend_b & (~pend_a | ~last_q);
        access_now = (state_q == BUSY) && (cnt_q == '0);
        if (grant_b) begin
            addr_d  = bus.address_b[ADDR_BITS:1];
            wmask_d = bus.wmask_b;
            wdata_d = bus.wdata_b;
            wr_d    = bus.write_b;
        end else begin
            addr_d  = bus.address_a[ADDR_BITS:1];
            wmask_d = bus.wmask_a;
            wdata_d = bus.wdata_a;
            wr_d    = bus.write_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            last_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wmask_q   <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            resp_a_q  <= 1'b0;
            resp_b_q  <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_a | pend_b) begin
                        port_q  <= grant_b;
                        last_q  <= grant_b;
                        addr_q  <= addr_d;
                        wmask_q <= wmask_d;
                        wdata_q <= wdata_d;
                        wr_q    <= wr_d;
                        cnt_q   <= CNT_INIT;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        if (!wr_q) begin
                            if (port_q) rdata_b_q <= mem[addr_q];
                            else        rdata_a_q <= mem[addr_q];
                        end
                        if (port_q) resp_b_q <= 1'b1;
                        else        resp_a_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    resp_a_q <= 1'b0;
                    resp_b_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array is not reset; the rst_n term keeps a reset edge from committing a write
    always_ff @(posedge clk) begin
        if (rst_n && access_now && wr_q) begin
            if (wmask_q[0]) mem[addr_q][7:0]  <= wdata_q[7:0];
            if (wmask_q[1]) mem[addr_q][15:8] <= wdata_q[15:8];
        end
    end

    assign bus.resp_a  = resp_a_q;
    assign bus.resp_b  = resp_b_q;
    assign bus.rdata_a = rdata_a_q;
    assign bus.rdata_b = rdata_b_q;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized traffic against a transaction-level memory model.
module tb_dual_port_mem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    dual_port_mem_responder_if dut_if ();

    dual_port_mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: word array, per-port read data, last grant
    logic [15:0] mem_m [256];
    logic [15:0] rd_m  [2];
    bit          last_m;

    typedef struct {
        bit          port;
        bit          rd;
        bit          wr;
        logic [1:0]  mask;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_apply(input bit p, input bit wr, input logic [1:0] m,
                                        input logic [15:0] a, input logic [15:0] d);
        int unsigned idx;
        idx = (int'(a) / 2) % 256;
        if (wr) begin
            if (m[0]) mem_m[idx][7:0]  = d[7:0];
            if (m[1]) mem_m[idx][15:8] = d[15:8];
        end else begin
            rd_m[p] = mem_m[idx];
        end
        last_m = p;
    endfunction

    task automatic drop_all();
        dut_if.read_a = 1'b0; dut_if.write_a = 1'b0;
        dut_if.read_b = 1'b0; dut_if.write_b = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drop_all();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rd_m[0] = '0; rd_m[1] = '0; last_m = 1'b0;
    endtask

    // Issue one request per enabled port; each port drops its request on resp
    task automatic service(input bit va, input bit ra, input bit wa, input logic [1:0] ma,
                           input logic [15:0] aa, input logic [15:0] da,
                           input bit vb, input bit rb, input bit wb, input logic [1:0] mb,
                           input logic [15:0] ab, input logic [15:0] db);
        int cyc, exp_a, exp_b;
        bit pa, pb;
        logic [15:0] er_a, er_b;
        exp_a = LAT + 1; exp_b = LAT + 1;
        if (va && vb) begin
            if (!last_m) begin
                model_apply(1'b1, wb, mb, ab, db); model_apply(1'b0, wa, ma, aa, da);
                exp_a = 2 * LAT + 3;
            end else begin
                model_apply(1'b0, wa, ma, aa, da); model_apply(1'b1, wb, mb, ab, db);
                exp_b = 2 * LAT + 3;
            end
        end else if (va) model_apply(1'b0, wa, ma, aa, da);
        else if (vb)     model_apply(1'b1, wb, mb, ab, db);
        er_a = rd_m[0]; er_b = rd_m[1];
        dut_if.read_a = va & ra; dut_if.write_a = va & wa; dut_if.wmask_a = ma;
        dut_if.address_a = aa;   dut_if.wdata_a = da;
        dut_if.read_b = vb & rb; dut_if.write_b = vb & wb; dut_if.wmask_b = mb;
        dut_if.address_b = ab;   dut_if.wdata_b = db;
        pa = va; pb = vb; cyc = 0;
        while ((pa || pb) && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (dut_if.resp_a) begin
                if (!pa) chk("resp_a_unrequested", 32'(pa), 32'd1);
                else begin
                    chk("latency_a", cyc, exp_a);
                    chk("rdata_a", dut_if.rdata_a, er_a);
                    pa = 1'b0; dut_if.read_a = 1'b0; dut_if.write_a = 1'b0;
                end
            end
            if (dut_if.resp_b) begin
                if (!pb) chk("resp_b_unrequested", 32'(pb), 32'd1);
                else begin
                    chk("latency_b", cyc, exp_b);
                    chk("rdata_b", dut_if.rdata_b, er_b);
                    pb = 1'b0; dut_if.read_b = 1'b0; dut_if.write_b = 1'b0;
                end
            end
        end
        if (pa || pb) chk("service_timeout", {pa, pb}, 32'd0);
        drop_all();
        @(posedge clk); #1;
        chk("resp_single_cycle", {dut_if.resp_a, dut_if.resp_b}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (dut_if.resp_a && dut_if.resp_b) begin
            failures++;
            $display("FAIL resp_overlap resp_a=1 resp_b=1 expected at most one at %0t", $time);
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, got_c;
        bit p, rd, wr, pa, pb;
        int op;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'hBEEF, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0000, 16'hBEEF};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'b01, 16'h3000, 16'h1234, 16'hBEEF};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0000, 16'hBE34};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'b10, 16'h3000, 16'h1234, 16'hBE34};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0000, 16'h1234};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'b11, 16'h0002, 16'hA5A5, 16'h0000};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b11, 16'h0202, 16'h0000, 16'hA5A5};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'b11, 16'h0003, 16'h5A5A, 16'hA5A5};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'b11, 16'h0202, 16'h0000, 16'h5A5A};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'b00, 16'h1202, 16'h0000, 16'h5A5A};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 16'h0202, 16'h00FF, 16'h5A5A};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'b11, 16'h0002, 16'h0000, 16'h5A5A};

        drop_all();
        dut_if.wmask_a = '0; dut_if.address_a = '0; dut_if.wdata_a = '0;
        dut_if.wmask_b = '0; dut_if.address_b = '0; dut_if.wdata_b = '0;
        apply_reset();
        chk("reset_resp", {dut_if.resp_a, dut_if.resp_b}, 32'd0);
        chk("reset_rdata_a", dut_if.rdata_a, 32'd0);
        chk("reset_rdata_b", dut_if.rdata_b, 32'd0);

        for (int i = 0; i < 256; i++)
            service(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0,
                    1'b1, 1'b0, 1'b1, 2'b11, 16'(i * 2), 16'($urandom));

        apply_reset();
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].port)
                service(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0,
                        1'b1, tbl[i].rd, tbl[i].wr, tbl[i].mask, tbl[i].addr, tbl[i].wdata);
            else
                service(1'b1, tbl[i].rd, tbl[i].wr, tbl[i].mask, tbl[i].addr, tbl[i].wdata,
                        1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
            chk($sformatf("table_rdata_%0d", i),
                tbl[i].port ? dut_if.rdata_b : dut_if.rdata_a, tbl[i].exp_rd);
        end

        // Both reads held from reset: grants go B,A,B,A every LAT+2 cycles
        apply_reset();
        dut_if.read_a = 1'b1; dut_if.address_a = 16'h0040;
        dut_if.read_b = 1'b1; dut_if.address_b = 16'h0082;
        for (c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            chk("alternate_resp_a", dut_if.resp_a, 32'(c == 7 || c == 15));
            chk("alternate_resp_b", dut_if.resp_b, 32'(c == 3 || c == 11));
        end
        drop_all();
        model_apply(1'b1, 1'b0, 2'b00, 16'h0082, 16'h0); model_apply(1'b0, 1'b0, 2'b00, 16'h0040, 16'h0);
        model_apply(1'b1, 1'b0, 2'b00, 16'h0082, 16'h0); model_apply(1'b0, 1'b0, 2'b00, 16'h0040, 16'h0);
        chk("alternate_rdata_a", dut_if.rdata_a, rd_m[0]);
        chk("alternate_rdata_b", dut_if.rdata_b, rd_m[1]);
        @(posedge clk); #1;
        chk("alternate_quiet", {dut_if.resp_a, dut_if.resp_b}, 32'd0);

        // Read held across resp into the following IDLE cycle, then dropped
        dut_if.read_a = 1'b1; dut_if.address_a = 16'h0010;
        n = 0; got_c = 0;
        for (c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (dut_if.resp_a) begin n++; if (n == 1) got_c = c; end
            if (c == 4) dut_if.read_a = 1'b0;
        end
        model_apply(1'b0, 1'b0, 2'b00, 16'h0010, 16'h0);
        chk("held_resp_count", n, 32'd1);
        chk("held_latency", got_c, LAT + 1);
        chk("held_rdata", dut_if.rdata_a, rd_m[0]);

        // Request dropped mid-BUSY still completes
        dut_if.read_a = 1'b1; dut_if.address_a = 16'h0020;
        @(posedge clk); #1;
        dut_if.read_a = 1'b0;
        got_c = 0;
        for (c = 2; c <= 10 && got_c == 0; c++) begin
            @(posedge clk); #1;
            if (dut_if.resp_a) got_c = c;
        end
        model_apply(1'b0, 1'b0, 2'b00, 16'h0020, 16'h0);
        chk("dropped_latency", got_c, LAT + 1);
        chk("dropped_rdata", dut_if.rdata_a, rd_m[0]);
        @(posedge clk); #1;

        // Reset during BUSY of a B write aborts it
        dut_if.write_b = 1'b1; dut_if.address_b = 16'h3000;
        dut_if.wdata_b = 16'h7777; dut_if.wmask_b = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        drop_all();
        #1;
        chk("abort_resp_b", dut_if.resp_b, 32'd0);
        chk("abort_rdata_a", dut_if.rdata_a, 32'd0);
        chk("abort_rdata_b", dut_if.rdata_b, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_resp_hold", {dut_if.resp_a, dut_if.resp_b}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_m[0] = '0; rd_m[1] = '0; last_m = 1'b0;
        service(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0,
                1'b1, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0);

        // Random traffic, single and simultaneous requests
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 2);
            pa = (op != 1); pb = (op != 0);
            begin
                logic [1:0] ma, mb;
                logic [15:0] aa, ab, da, db;
                bit ra, wa, rb, wb;
                int oa, ob;
                oa = $urandom_range(0, 2); ob = $urandom_range(0, 2);
                ra = (oa != 1); wa = (oa != 0);
                rb = (ob != 1); wb = (ob != 0);
                ma = 2'($urandom); mb = 2'($urandom);
                aa = 16'($urandom); ab = 16'($urandom);
                da = 16'($urandom); db = 16'($urandom);
                service(pa, ra, wa, ma, aa, da, pb, rb, wb, mb, ab, db);
            end
        end
        chk("final_rdata_a", dut_if.rdata_a, rd_m[0]);
        chk("final_rdata_b", dut_if.rdata_b, rd_m[1]);

        p = 1'b0; rd = 1'b0; wr = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
